// File: rtl/icache.sv
// icache: direct-mapped instruction cache (2^INDEX_WIDTH lines, one 32-bit fetch word per line).
// Define ICACHE_STAT_EN to add the hit_cnt/miss_cnt lookup statistics ports.
module icache #(
  parameter int INDEX_WIDTH = 6,
  parameter int ADDR_WIDTH  = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        invalidate,
  input  logic        icache_enable,
  input  logic [31:0] icache_addr,
  output logic        icache_hit,
  output logic [31:0] icache_data,
  input  logic        write_ready,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_inst
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 1;

  // I/O space and odd addresses are never cached.
  function automatic logic is_cacheable(input logic [31:0] addr);
    return (addr[17:16] != 2'b11) && (addr[0] == 1'b0);
  endfunction

  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [31:0]            line_q [LINES];
  logic                   hit_q, hit_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [INDEX_WIDTH-1:0] rd_idx_s, wr_idx_s;
  logic [TAG_W-1:0]       rd_tag_s, wr_tag_s;
  logic                   fill_s, raw_hit_s, lk_hit_s;
  logic [31:0]            lk_word_s;
  logic                   unused_addr_s;

  assign rd_idx_s = icache_addr[INDEX_WIDTH:1];
  assign wr_idx_s = write_addr[INDEX_WIDTH:1];
  assign rd_tag_s = icache_addr[ADDR_WIDTH-1:INDEX_WIDTH+1];
  assign wr_tag_s = write_addr[ADDR_WIDTH-1:INDEX_WIDTH+1];
  assign unused_addr_s = ^{icache_addr[31:ADDR_WIDTH], write_addr[31:ADDR_WIDTH]};

  // invalidate wins over a same-cycle fill
  assign fill_s   = rdy_in & write_ready & ~invalidate & is_cacheable(write_addr);
  assign lk_hit_s = raw_hit_s & icache_enable & ~invalidate & is_cacheable(icache_addr);

  // Tag compare with write-first bypass when a fill targets the looked-up line
  always_comb begin
    lk_word_s = line_q[rd_idx_s];
    raw_hit_s = 1'b0;
    if (fill_s && (wr_idx_s == rd_idx_s)) begin
      lk_word_s = write_inst;
      raw_hit_s = (wr_tag_s == rd_tag_s);
    end else begin
      raw_hit_s = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_tag_s);
    end
  end

  // Next-state for valid bits and the registered lookup stage
  always_comb begin
    valid_d = valid_q;
    hit_d   = hit_q;
    rdata_d = rdata_q;
    if (rdy_in) begin
      hit_d = lk_hit_s;
      if (lk_hit_s) begin
        rdata_d = lk_word_s;
      end else begin
        rdata_d = rdata_q;
      end
      if (invalidate) begin
        valid_d = '0;
      end else if (fill_s) begin
        valid_d[wr_idx_s] = 1'b1;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits and lookup outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
      hit_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
    end
  end

  // Tag/data storage; contents are qualified by valid_q so no reset needed
  always_ff @(posedge clk_in) begin
    if (fill_s) begin
      tag_q[wr_idx_s]  <= wr_tag_s;
      line_q[wr_idx_s] <= write_inst;
    end
  end

  assign icache_hit  = hit_q;
  assign icache_data = rdata_q;

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Exactly one counter advances per accepted lookup
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rdy_in && icache_enable) begin
      if (lk_hit_s) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end else begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt_q  <= 32'h0000_0000;
      miss_cnt_q <= 32'h0000_0000;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache; lookup expectations are queued as stimulus is
// driven and popped once the registered result appears.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, invalidate, icache_enable, write_ready;
  logic [31:0] icache_addr, write_addr, write_inst;
  logic        icache_hit;
  logic [31:0] icache_data;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rdy;
    logic        inv;
    logic        en;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] winst;
    logic        eh;
    logic [31:0] ed;
  } row_t;

  typedef struct {
    logic        hit;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  icache dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .invalidate(invalidate),
    .icache_enable(icache_enable), .icache_addr(icache_addr),
    .icache_hit(icache_hit), .icache_data(icache_data),
    .write_ready(write_ready), .write_addr(write_addr), .write_inst(write_inst)
`ifdef ICACHE_STAT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  function automatic row_t mk(logic rdy, logic inv, logic en, logic [31:0] addr, logic wr,
                              logic [31:0] waddr, logic [31:0] winst, logic eh, logic [31:0] ed);
    row_t r;
    r.rdy = rdy; r.inv = inv; r.en = en; r.addr = addr; r.wr = wr;
    r.waddr = waddr; r.winst = winst; r.eh = eh; r.ed = ed;
    return r;
  endfunction

  function automatic row_t lk(logic [31:0] addr, logic eh, logic [31:0] ed);
    return mk(1'b1, 1'b0, 1'b1, addr, 1'b0, 32'h0, 32'h0, eh, ed);
  endfunction

  function automatic row_t fl(logic [31:0] waddr, logic [31:0] winst, logic [31:0] ed);
    return mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, waddr, winst, 1'b0, ed);
  endfunction

  task automatic drive(input row_t r);
    rdy_in = r.rdy; invalidate = r.inv; icache_enable = r.en; icache_addr = r.addr;
    write_ready = r.wr; write_addr = r.waddr; write_inst = r.winst;
    sb.push_back('{hit: r.eh, data: r.ed});
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; invalidate = 1'b0; icache_enable = 1'b0; icache_addr = 32'h0;
    write_ready = 1'b0; write_addr = 32'h0; write_inst = 32'h0;
  endtask

  task automatic test_reset();
    row_t rows [2];
    exp_t e;
    rst_in = 1'b0;
    idle();
    cyc(); cyc();
    n_checks++;
    if (icache_hit !== 1'b0 || icache_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_init: hit=%b data=%h, want 0/00000000", icache_hit, icache_data);
    end
    #3 rst_in = 1'b1;
    rows = '{fl(32'h1000, 32'h1234_5678, 32'h0), lk(32'h1000, 1'b1, 32'h1234_5678)};
    foreach (rows[i]) begin
      drive(rows[i]); cyc(); e = sb.pop_front();
      n_checks++;
      if (icache_hit !== e.hit || icache_data !== e.data) begin
        n_fail++; $display("FAIL reset_pre[%0d]: hit=%b data=%h, want %b/%h", i, icache_hit, icache_data, e.hit, e.data);
      end
    end
    // reset asserted mid-cycle while a hitting lookup is pending
    drive(lk(32'h1000, 1'b0, 32'h0));
    #2 rst_in = 1'b0;
    #1;
    n_checks++;
    if (icache_hit !== 1'b0 || icache_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_async: hit=%b data=%h, want 0/00000000", icache_hit, icache_data);
    end
    cyc();
    #3 rst_in = 1'b1;
    cyc(); e = sb.pop_front();
    n_checks++;
    if (icache_hit !== e.hit || icache_data !== e.data) begin
      n_fail++; $display("FAIL reset_lookup: hit=%b data=%h, want %b/%h", icache_hit, icache_data, e.hit, e.data);
    end
  endtask

  task automatic test_hit();
    row_t rows [3];
    exp_t e;
    rows = '{fl(32'h1000, 32'h0000_0513, 32'h0),
             lk(32'h1000, 1'b1, 32'h0000_0513),
             fl(32'h1040, 32'h9999_9999, 32'h0000_0513)};
    foreach (rows[i]) begin
      drive(rows[i]); cyc(); e = sb.pop_front();
      n_checks++;
      if (icache_hit !== e.hit || icache_data !== e.data) begin
        n_fail++; $display("FAIL hit[%0d]: hit=%b data=%h, want %b/%h", i, icache_hit, icache_data, e.hit, e.data);
      end
    end
  endtask

  task automatic test_conflict();
    row_t rows [3];
    exp_t e;
    rows = '{fl(32'h1080, 32'hCAFE_0001, 32'h0000_0513),
             lk(32'h1000, 1'b0, 32'h0000_0513),
             lk(32'h1080, 1'b1, 32'hCAFE_0001)};
    foreach (rows[i]) begin
      drive(rows[i]); cyc(); e = sb.pop_front();
      n_checks++;
      if (icache_hit !== e.hit || icache_data !== e.data) begin
        n_fail++; $display("FAIL conflict[%0d]: hit=%b data=%h, want %b/%h", i, icache_hit, icache_data, e.hit, e.data);
      end
    end
  endtask

  task automatic test_bypass();
    row_t rows [7];
    exp_t e;
    rows = '{mk(1'b1, 1'b0, 1'b1, 32'h1002, 1'b1, 32'h1002, 32'hABCD_4501, 1'b1, 32'hABCD_4501),
             mk(1'b1, 1'b0, 1'b1, 32'h1002, 1'b1, 32'h3_0000, 32'hDEAD_BEEF, 1'b1, 32'hABCD_4501),
             lk(32'h3_0000, 1'b0, 32'hABCD_4501),
             lk(32'h1080, 1'b1, 32'hCAFE_0001),
             mk(1'b1, 1'b0, 1'b1, 32'h1002, 1'b1, 32'h1082, 32'h5555_0000, 1'b0, 32'hCAFE_0001),
             mk(1'b1, 1'b0, 1'b1, 32'h1082, 1'b1, 32'h1004, 32'h0000_7777, 1'b1, 32'h5555_0000),
             lk(32'h1005, 1'b0, 32'h5555_0000)};
    foreach (rows[i]) begin
      drive(rows[i]); cyc(); e = sb.pop_front();
      n_checks++;
      if (icache_hit !== e.hit || icache_data !== e.data) begin
        n_fail++; $display("FAIL bypass[%0d]: hit=%b data=%h, want %b/%h", i, icache_hit, icache_data, e.hit, e.data);
      end
    end
  endtask

  task automatic test_invalidate();
    row_t rows [4];
    exp_t e;
    rows = '{lk(32'h1004, 1'b1, 32'h0000_7777),
             mk(1'b1, 1'b1, 1'b1, 32'h1004, 1'b1, 32'h2000, 32'h0000_2222, 1'b0, 32'h0000_7777),
             lk(32'h2000, 1'b0, 32'h0000_7777),
             lk(32'h1080, 1'b0, 32'h0000_7777)};
    foreach (rows[i]) begin
      drive(rows[i]); cyc(); e = sb.pop_front();
      n_checks++;
      if (icache_hit !== e.hit || icache_data !== e.data) begin
        n_fail++; $display("FAIL invalidate[%0d]: hit=%b data=%h, want %b/%h", i, icache_hit, icache_data, e.hit, e.data);
      end
    end
  endtask

  task automatic test_rdy_pause();
    row_t rows [7];
    exp_t e;
    rows = '{fl(32'h3000, 32'h0BAD_F00D, 32'h0000_7777),
             lk(32'h3000, 1'b1, 32'h0BAD_F00D),
             mk(1'b0, 1'b1, 1'b1, 32'h1080, 1'b1, 32'h3080, 32'h0000_0001, 1'b1, 32'h0BAD_F00D),
             mk(1'b0, 1'b1, 1'b1, 32'h1080, 1'b1, 32'h3080, 32'h0000_0001, 1'b1, 32'h0BAD_F00D),
             mk(1'b0, 1'b1, 1'b1, 32'h1080, 1'b1, 32'h3080, 32'h0000_0001, 1'b1, 32'h0BAD_F00D),
             lk(32'h3000, 1'b1, 32'h0BAD_F00D),
             lk(32'h3080, 1'b0, 32'h0BAD_F00D)};
    foreach (rows[i]) begin
      drive(rows[i]); cyc(); e = sb.pop_front();
      n_checks++;
      if (icache_hit !== e.hit || icache_data !== e.data) begin
        n_fail++; $display("FAIL rdy_pause[%0d]: hit=%b data=%h, want %b/%h", i, icache_hit, icache_data, e.hit, e.data);
      end
    end
  endtask

`ifdef ICACHE_STAT_EN
  task automatic test_stats();
    row_t rows [9];
    exp_t e;
    idle();
    #2 rst_in = 1'b0;
    cyc();
    n_checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++; $display("FAIL stats_reset: hit_cnt=%0d miss_cnt=%0d, want 0/0", hit_cnt, miss_cnt);
    end
    #3 rst_in = 1'b1;
    rows = '{fl(32'h4000, 32'h0000_0044, 32'h0),
             lk(32'h4000, 1'b1, 32'h0000_0044),
             lk(32'h4000, 1'b1, 32'h0000_0044),
             lk(32'h4100, 1'b0, 32'h0000_0044),
             lk(32'h4000, 1'b1, 32'h0000_0044),
             lk(32'h3_0000, 1'b0, 32'h0000_0044),
             mk(1'b0, 1'b0, 1'b1, 32'h4000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0044),
             mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0044),
             lk(32'h4000, 1'b0, 32'h0000_0044)};
    foreach (rows[i]) begin
      drive(rows[i]); cyc(); e = sb.pop_front();
      n_checks++;
      if (icache_hit !== e.hit || icache_data !== e.data) begin
        n_fail++; $display("FAIL stats_seq[%0d]: hit=%b data=%h, want %b/%h", i, icache_hit, icache_data, e.hit, e.data);
      end
      if (i == 6) begin
        n_checks++;
        if (hit_cnt !== 32'd3 || miss_cnt !== 32'd2) begin
          n_fail++; $display("FAIL stats_count: hit_cnt=%0d miss_cnt=%0d, want 3/2", hit_cnt, miss_cnt);
        end
      end
      if (i == 7) begin
        n_checks++;
        if (hit_cnt !== 32'd3 || miss_cnt !== 32'd2) begin
          n_fail++; $display("FAIL stats_inval: hit_cnt=%0d miss_cnt=%0d, want 3/2", hit_cnt, miss_cnt);
        end
      end
    end
    n_checks++;
    if (hit_cnt !== 32'd3 || miss_cnt !== 32'd3) begin
      n_fail++; $display("FAIL stats_final: hit_cnt=%0d miss_cnt=%0d, want 3/3", hit_cnt, miss_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hit();
    test_conflict();
    test_bypass();
    test_invalidate();
    test_rdy_pause();
`ifdef ICACHE_STAT_EN
    test_stats();
`endif
    idle();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
